// File: rtl/rv32i_pkg.sv
// Shared RV32I write-back constants and types.
package rv32i_pkg;

   typedef logic [4:0]  reg_addr_t;
   typedef logic [31:0] word_t;

   localparam logic [6:0] OPC_JAL  = 7'b1101111;
   localparam logic [6:0] OPC_JALR = 7'b1100111;
   localparam word_t      NOP_IW   = 32'h0000_0013;

endpackage

// File: rtl/rv32i_regfile.sv
// 31-entry architectural register file, x0 hardwired to zero, with
// write-through bypass on both combinational read ports.
module rv32i_regfile
   import rv32i_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        we_i,
   input  logic [4:0]  rd_i,
   input  logic [31:0] wd_i,
   input  logic [4:0]  rs1_addr_i,
   input  logic [4:0]  rs2_addr_i,
   output logic [31:0] rs1_data_o,
   output logic [31:0] rs2_data_o
);

   word_t regs_q [1:31];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned i = 1; i < 32; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i && (rd_i != '0)) begin
         regs_q[rd_i] <= wd_i;
      end
   end

   // A committing write is visible to a same-cycle read of the same register.
   always_comb begin
      rs1_data_o = '0;
      if (rs1_addr_i != '0) begin
         if (we_i && (rs1_addr_i == rd_i)) begin
            rs1_data_o = wd_i;
         end else begin
            rs1_data_o = regs_q[rs1_addr_i];
         end
      end
   end

   always_comb begin
      rs2_data_o = '0;
      if (rs2_addr_i != '0) begin
         if (we_i && (rs2_addr_i == rd_i)) begin
            rs2_data_o = wd_i;
         end else begin
            rs2_data_o = regs_q[rs2_addr_i];
         end
      end
   end

endmodule

// File: rtl/rv32i_wb_top.sv
// RV32I write-back stage: selects the write-back value, owns the register file
// and drives the forwarding tap. Optional retire counter under RV32I_INSTRET_EN.
module rv32i_wb_top #(
   parameter int unsigned DATA_W = 32,
   parameter logic [31:0] NOP_IW = rv32i_pkg::NOP_IW
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wb_en_in,
   input  logic [DATA_W-1:0] pc_in,
   input  logic [31:0]       iw_in,
   input  logic [DATA_W-1:0] alu_in,
   input  logic [4:0]        rs1_addr,
   input  logic [4:0]        rs2_addr,
   output logic [DATA_W-1:0] rs1_data,
   output logic [DATA_W-1:0] rs2_data,
   output logic              fwd_en,
   output logic [4:0]        fwd_rd,
   output logic [DATA_W-1:0] fwd_data
`ifdef RV32I_INSTRET_EN
   ,
   output logic [63:0]       retire_count
`endif
);

   import rv32i_pkg::*;

   reg_addr_t rd;
   logic [6:0] opcode;
   word_t wb_data;
   logic we;

   assign rd     = iw_in[11:7];
   assign opcode = iw_in[6:0];

   // Link value wraps naturally at 32 bits.
   always_comb begin
      wb_data = alu_in;
      if ((opcode == OPC_JAL) || (opcode == OPC_JALR)) begin
         wb_data = pc_in + 32'd4;
      end
   end

   assign we = wb_en_in && (rd != '0);

   assign fwd_en   = we;
   assign fwd_rd   = rd;
   assign fwd_data = wb_data;

   rv32i_regfile u_regfile (
      .clk_i      (clk),
      .rst_i      (reset),
      .we_i       (we),
      .rd_i       (rd),
      .wd_i       (wb_data),
      .rs1_addr_i (rs1_addr),
      .rs2_addr_i (rs2_addr),
      .rs1_data_o (rs1_data),
      .rs2_data_o (rs2_data)
   );

`ifdef RV32I_INSTRET_EN
   logic [63:0] retire_q, retire_d;

   always_comb begin
      retire_d = retire_q;
      if ((iw_in != '0) && (iw_in != NOP_IW)) begin
         retire_d = retire_q + 64'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         retire_q <= '0;
      end else begin
         retire_q <= retire_d;
      end
   end

   assign retire_count = retire_q;
`else
   // Upper instruction bits and NOP_IW only feed the retire counter.
   logic unused_cfg;
   assign unused_cfg = ^{iw_in[31:12], NOP_IW};
`endif

endmodule

// File: doc/rv32i_wb_top.md
# rv32i_wb_top

Write-back stage of the RV32I five-stage pipeline. Consumes the registered PC, instruction word, ALU result and write-enable from the memory stage and selects the write-back value. Owns the 32×32 architectural register file, with two combinational read ports for decode. Provides write-through bypass and a forwarding tap for hazard logic.

## Interface
Parameters:
- DATA_W, 32, datapath and register width; only 32 is supported.
- NOP_IW, 32'h0000_0013, canonical NOP encoding (addi x0,x0,0); excluded from retire counting.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- wb_en_in  input  1  write-back enable from memory stage.
- pc_in  input  32  PC of the instruction in write-back.
- iw_in  input  32  instruction word in write-back.
- alu_in  input  32  ALU result from memory stage.
- rs1_addr  input  5  decode read port 1 address.
- rs2_addr  input  5  decode read port 2 address.
- rs1_data  output  32  read port 1 data, combinational.
- rs2_data  output  32  read port 2 data, combinational.
- fwd_en  output  1  write committing this cycle, combinational.
- fwd_rd  output  5  destination register of the committing write.
- fwd_data  output  32  value being written.
- retire_count  output  64  retired-instruction count; present only with RV32I_INSTRET_EN.

## Operation
- rd = iw_in[11:7]; opcode = iw_in[6:0].
- Write-back data: if opcode is JAL (7'b1101111) or JALR (7'b1100111), wb_data = pc_in + 4, truncated to 32 bits with wrap-around (32'hFFFF_FFFC + 4 = 0). Otherwise wb_data = alu_in.
- Write commit: we = wb_en_in && (rd != 0). When we is 1, regs[rd] <= wb_data on posedge clk.
- x0 is hardwired to zero. It is never stored; a read of address 0 returns 0 regardless of writes.
- Read ports, for each port independently:
  - address 0 returns 0;
  - else if we and address == rd, returns wb_data (write-through bypass);
  - else returns regs[address].
- Both ports may read the same address; both return identical data.
- fwd_en = we, fwd_rd = rd, fwd_data = wb_data. fwd_rd and fwd_data are driven unconditionally; consumers qualify them with fwd_en.
- The block itself adds no pipeline register; the instruction retires in the cycle it is presented.

## Timing
- Reset asserts asynchronously: all 31 storage registers go to 0 immediately, and retire_count goes to 0.
- During reset, rs1_data and rs2_data read 0 unless bypassed. The write itself is blocked while reset is high.
- When reset deasserts mid-operation, the first write is accepted on the first posedge with reset low.
- Write latency: value visible via bypass in the same cycle, and from storage starting the cycle after the posedge.
- Read latency: zero cycles (combinational from address, storage and write-back inputs).
- Back-to-back writes to the same rd: the last write wins; each cycle's bypass reflects that cycle's wb_data.
- Simultaneous write and read of the same register: the read returns the new value.

## Configuration
- RV32I_INSTRET_EN defined: a 64-bit retire_count register is added.
  - It increments by 1 on each posedge where iw_in != 0 and iw_in != NOP_IW, independent of wb_en_in.
  - It wraps from 2^64−1 to 0.
- RV32I_INSTRET_EN undefined: no counter logic and no retire_count port.

## Structure
- The shared package rv32i_pkg holds:
  - the OPC_JAL and OPC_JALR constants;
  - the NOP_IW value;
  - a reg_addr_t typedef (logic [4:0]);
  - a word_t typedef (logic [31:0]).
- One sub-module, rv32i_regfile, contains the storage, x0 handling, the write port and both bypassed read ports.
- rv32i_wb_top contains the data selection, the forwarding outputs and the optional counter.

## Test plan
- Reset check: assert reset mid-run after writing x5 = 32'hDEAD_BEEF; reading x5 then returns 0, and retire_count = 0.
- Normal write: iw_in = add x7 (rd = 7), alu_in = 32'h1234_5678, wb_en_in = 1. fwd_en = 1 that cycle. rs1_addr = 7 returns 32'h1234_5678 in the same cycle via bypass and in the next cycle from storage.
- JAL write-back: pc_in = 32'h0000_0100, iw_in = jal x1. x1 = 32'h0000_0104. With pc_in = 32'hFFFF_FFFC, x1 = 32'h0000_0000.
- x0 write attempt: rd = 0, wb_en_in = 1, alu_in = 32'hFFFF_FFFF. fwd_en = 0, and reading x0 returns 0.
- Suppressed write: wb_en_in = 0 with rd = 3 and alu_in = 32'hAAAA_AAAA. x3 is unchanged.
- Retire counter (RV32I_INSTRET_EN): feed 3 valid instructions, 2 NOPs (32'h0000_0013) and 1 zero word. retire_count = 3.
